// File: rtl/reg_pipe_pkg.sv
// Shared helpers for the reg_pipe register pipeline.
package reg_pipe_pkg;

  // Width of an occupancy counter that can hold 0..depth; never narrower than 1 bit.
  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One slice of the register pipeline: a valid bit plus a data register.
// The slice can take new data whenever it is empty or its downstream neighbour
// is taking its current contents, which is what lets bubbles collapse.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  assign ready = !valid || down_ready;

  // Reset wins, flush only drops the valid bit, otherwise load when ready (data holds on bubbles).
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// Parametrised valid/ready register pipeline with bubble collapsing,
// programmable data reset value, synchronous flush and a registered
// occupancy count. DEPTH=0 degenerates to a combinational pass-through.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               OCC_W       = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH == 0) begin : g_bypass
    // No storage: clock and reset have nothing to act on in this configuration.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    assign in_ready  = out_ready && !flush;
    assign out_valid = in_valid && !flush;
    assign out_data  = in_data;
    assign occupancy = '0;
  end else begin : g_pipe
    logic in_xfer;
    logic out_xfer;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             up_valid;
      logic             down_ready;
      logic             ready;
      logic             valid;
      logic [WIDTH-1:0] up_data;
      logic [WIDTH-1:0] data;

      if (i == 0) begin : g_first
        assign up_valid = in_valid && !flush;
        assign up_data  = in_data;
      end else begin : g_next
        assign up_valid = g_stage[i-1].valid;
        assign up_data  = g_stage[i-1].data;
      end

      if (i == DEPTH - 1) begin : g_last
        assign down_ready = out_ready;
      end else begin : g_mid
        assign down_ready = g_stage[i+1].ready;
      end

      reg_pipe_stage #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RESET_VALUE)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .up_valid  (up_valid),
        .up_data   (up_data),
        .down_ready(down_ready),
        .ready     (ready),
        .valid     (valid),
        .data      (data)
      );
    end

    assign in_ready  = g_stage[0].ready && !flush;
    assign out_valid = g_stage[DEPTH-1].valid && !flush;
    assign out_data  = g_stage[DEPTH-1].data;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Occupancy tracks the number of valid stages: +1 per accept, -1 per delivery, cleared by flush.
    always_ff @(posedge clk) begin
      if (reset) begin
        occupancy <= '0;
      end else if (flush) begin
        occupancy <= '0;
      end else begin
        occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
      end
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe: a DEPTH=3 instance checked by a table of
// hand-derived vectors, a streaming sequence and a random run against a
// queue-based reference model, plus a DEPTH=0 pass-through instance.
module tb_reg_pipe;

  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, out_ready;
  logic       in_ready, out_valid;
  logic [7:0] in_data, out_data;
  logic [1:0] occupancy;

  logic       z_flush, z_in_valid, z_out_ready, z_in_ready, z_out_valid;
  logic [7:0] z_in_data, z_out_data;
  logic [0:0] z_occupancy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: items in order, each with its distance (in stages) from the output.
  logic [7:0] q_data[$];
  int         q_d[$];

  // Values sampled from the DUT in the middle of the most recent cycle.
  logic       s_ir, s_ov;
  logic [7:0] s_od;
  logic [1:0] s_occ;

  typedef struct {
    bit         rst, fl, iv;
    logic [7:0] din;
    bit         ordy, chk, ir, ov;
    logic [7:0] od;
    bit         cod;
    logic [1:0] occ;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VALUE(RV)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  reg_pipe #(.WIDTH(8), .DEPTH(0), .RESET_VALUE(8'h00)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .flush    (z_flush),
    .in_valid (z_in_valid),
    .in_ready (z_in_ready),
    .in_data  (z_in_data),
    .out_valid(z_out_valid),
    .out_ready(z_out_ready),
    .out_data (z_out_data),
    .occupancy(z_occupancy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check mid-cycle against the model, then advance the model at the clock edge.
  task automatic applyStimulus(input bit rst, input bit fl, input bit iv, input logic [7:0] din,
                               input bit ordy, input bit chk);
    bit p_ir, p_ov, in_x, out_x;
    reset = rst; flush = fl; in_valid = iv; in_data = din; out_ready = ordy;
    @(negedge clk);
    s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_occ = occupancy;
    p_ir = !fl && ((q_d.size() < D) || ordy);
    p_ov = 1'b0;
    if (q_d.size() > 0) p_ov = !fl && (q_d[0] == 0);
    if (chk) begin
      checkOutput("mdl_in_ready", 32'(s_ir), 32'(p_ir));
      checkOutput("mdl_out_valid", 32'(s_ov), 32'(p_ov));
      checkOutput("mdl_occupancy", 32'(s_occ), 32'(q_d.size()));
      if (p_ov) checkOutput("mdl_out_data", 32'(s_od), 32'(q_data[0]));
    end
    in_x  = iv && p_ir;
    out_x = p_ov && ordy;
    @(posedge clk);
    if (rst || fl) begin
      q_data.delete();
      q_d.delete();
    end else begin
      if (out_x) begin
        void'(q_data.pop_front());
        void'(q_d.pop_front());
      end
      for (int k = 0; k < q_d.size(); k++) begin
        int nd;
        nd = (q_d[k] > 0) ? q_d[k] - 1 : 0;
        if (k > 0 && nd < q_d[k-1] + 1) nd = q_d[k-1] + 1;
        q_d[k] = nd;
      end
      if (in_x) begin
        q_data.push_back(din);
        q_d.push_back(D - 1);
      end
    end
    #1;
  endtask

  function automatic vec_t mk(input bit rst, input bit fl, input bit iv, input logic [7:0] din,
                              input bit ordy, input bit chk, input bit ir, input bit ov,
                              input logic [7:0] od, input bit cod, input logic [1:0] occ);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy; v.chk = chk;
    v.ir = ir; v.ov = ov; v.od = od; v.cod = cod; v.occ = occ;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    z_flush = 1'b0; z_in_valid = 1'b0; z_in_data = '0; z_out_ready = 1'b0;

    //           rst fl iv din    ordy chk ir ov od     cod occ
    // reset held two cycles
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 0, RV,    1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, RV,    1, 0));
    // backpressure: 3 accepted, 4th refused until the head leaves
    tbl.push_back(mk(0, 0, 1, 8'h11, 0, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h12, 0, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 1, 8'h13, 0, 1, 1, 0, 8'h00, 0, 2));
    tbl.push_back(mk(0, 0, 1, 8'h14, 0, 1, 0, 1, 8'h11, 1, 3));
    tbl.push_back(mk(0, 0, 1, 8'h14, 1, 1, 1, 1, 8'h11, 1, 3));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h12, 1, 3));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h13, 1, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h14, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0));
    // bubble collapse under stall
    tbl.push_back(mk(0, 0, 1, 8'hA1, 0, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 1, 8'hB2, 0, 1, 1, 1, 8'hA1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 1, 8'hA1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 1, 8'hA1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'hA1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 1, 8'hB2, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'hC1, 0, 1, 1, 1, 8'hB2, 1, 1));
    // flush with two items and a new offer; data registers keep their contents
    tbl.push_back(mk(0, 1, 1, 8'hC3, 1, 1, 0, 0, 8'hB2, 1, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'hB2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'hB2, 1, 0));
    // reset together with flush behaves as reset (data back to RESET_VALUE)
    tbl.push_back(mk(0, 0, 1, 8'hE5, 0, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'hE6, 0, 1, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, RV,    1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, RV,    1, 0));
    // reset in the middle of a full stall discards everything
    tbl.push_back(mk(0, 0, 1, 8'h31, 0, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h32, 0, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 1, 8'h33, 0, 1, 1, 0, 8'h00, 0, 2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 1, 8'h31, 1, 3));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 0, RV,    1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 0, RV,    1, 0));

    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].din, tbl[i].ordy, tbl[i].chk);
      if (tbl[i].chk) begin
        checkOutput($sformatf("tbl%0d_in_ready", i), 32'(s_ir), 32'(tbl[i].ir));
        checkOutput($sformatf("tbl%0d_out_valid", i), 32'(s_ov), 32'(tbl[i].ov));
        checkOutput($sformatf("tbl%0d_occupancy", i), 32'(s_occ), 32'(tbl[i].occ));
        if (tbl[i].cod) checkOutput($sformatf("tbl%0d_out_data", i), 32'(s_od), 32'(tbl[i].od));
      end
    end

    // streaming 01..10 back-to-back with the sink always ready: 3-cycle latency, steady occupancy 3
    for (int k = 0; k < 19; k++) begin
      applyStimulus(0, 0, (k < 16), 8'(k + 1), 1, 1);
      if (k >= 3) begin
        checkOutput("stream_out_valid", 32'(s_ov), 32'd1);
        checkOutput("stream_out_data", 32'(s_od), 32'(k - 2));
      end else begin
        checkOutput("stream_out_valid_early", 32'(s_ov), 32'd0);
      end
      if (k >= 3 && k <= 16) checkOutput("stream_occupancy", 32'(s_occ), 32'd3);
    end

    // random traffic against the reference model
    for (int k = 0; k < 800; k++) begin
      bit r_rst, r_fl, r_iv, r_or;
      r_rst = ($urandom_range(0, 59) == 0);
      r_fl  = ($urandom_range(0, 24) == 0);
      r_iv  = ($urandom_range(0, 3) != 0);
      r_or  = (k % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      applyStimulus(r_rst, r_fl, r_iv, 8'($urandom), r_or, 1);
    end
    applyStimulus(0, 0, 0, 8'h00, 1, 1);

    // DEPTH=0 pass-through
    for (int k = 0; k < 40; k++) begin
      z_in_valid  = 1'($urandom);
      z_out_ready = 1'($urandom);
      z_flush     = ($urandom_range(0, 4) == 0);
      z_in_data   = 8'($urandom);
      @(negedge clk);
      checkOutput("d0_out_valid", 32'(z_out_valid), 32'(z_in_valid && !z_flush));
      checkOutput("d0_out_data", 32'(z_out_data), 32'(z_in_data));
      checkOutput("d0_in_ready", 32'(z_in_ready), 32'(z_out_ready && !z_flush));
      checkOutput("d0_occupancy", 32'(z_occupancy), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
